// File: rtl/mont_mul_r2.sv
// rtl/mont_mul_r2.sv - radix-2 iterative Montgomery multiplier, start/done handshake (option: MONT_FINAL_SUB_EN)
module mont_mul_r2 #(
    parameter int WIDTH = 1024
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOOP = 2'd1;
`ifdef MONT_FINAL_SUB_EN
    localparam logic [1:0] S_SUB  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH+1:0] c;
    logic [CW-1:0]    cnt;

    logic [WIDTH+1:0] t_add;
    logic [WIDTH+1:0] t_red;
    logic [WIDTH+1:0] c_next;
    logic             last_iter;
`ifdef MONT_FINAL_SUB_EN
    logic [WIDTH+1:0] c_sub;
`endif

    // C stays below 2M, so C + B + M < 4M fits in WIDTH+2 bits without truncation.
    always_comb begin
        t_add     = c + (a_sh[0] ? {2'b00, b_r} : {(WIDTH+2){1'b0}});
        t_red     = t_add[0] ? (t_add + {2'b00, m_r}) : t_add;
        c_next    = t_red >> 1;
        last_iter = (cnt == CW'(WIDTH - 1));
`ifdef MONT_FINAL_SUB_EN
        c_sub     = c - {2'b00, m_r};
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            b_r    <= '0;
            m_r    <= '0;
            c      <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= in_a;
                        b_r   <= in_b;
                        m_r   <= in_m;
                        c     <= '0;
                        cnt   <= '0;
                        state <= S_LOOP;
                    end
                end
                S_LOOP: begin
                    c    <= c_next;
                    a_sh <= a_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    if (last_iter) begin
`ifdef MONT_FINAL_SUB_EN
                        state  <= S_SUB;
`else
                        result <= c_next[WIDTH-1:0];
                        state  <= S_DONE;
`endif
                    end
                end
`ifdef MONT_FINAL_SUB_EN
                S_SUB: begin
                    result <= (c >= {2'b00, m_r}) ? c_sub[WIDTH-1:0] : c[WIDTH-1:0];
                    state  <= S_DONE;
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign done = (state == S_DONE);
    assign busy = (state != S_IDLE);

endmodule
